// File: rtl/addsub_pkg.sv
// Shared constants and FIFO entry type for the adder_sub result stage.
package addsub_pkg;

    localparam int WIDTH = 16;

    localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef struct packed {
        logic signed [WIDTH-1:0] res;
        logic                    over;
        logic                    carry;
        logic                    op;
        logic                    sat;
    } addsub_res_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/addsub_fifo2.sv
// Two-entry FIFO of addsub_res_t; occupancy is the state machine, in_ready is registered.
module addsub_fifo2
    import addsub_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  addsub_res_t din,
    output logic        out_valid,
    input  logic        out_ready,
    output addsub_res_t dout
);

    occ_t        state, state_nxt;
    logic        wptr, rptr;
    logic        in_ready_q;
    logic        push, pop;
    addsub_res_t mem [2];

    assign push      = in_valid && in_ready_q;
    assign out_valid = (state != EMPTY);
    assign pop       = out_valid && out_ready;
    assign in_ready  = in_ready_q;
    assign dout      = mem[rptr];

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = TWO;
                else if (pop && !push) state_nxt = EMPTY;
            end
            TWO:     if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // in_ready is a flop of the next occupancy, so out_ready never reaches it combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            wptr       <= wptr ^ push;
            rptr       <= rptr ^ pop;
            in_ready_q <= (state_nxt != TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

endmodule

// File: rtl/addsub_result_stage.sv
// Registered result stage behind adder_sub: 2-entry buffer, optional saturation, overflow stats.
// Define ADDSUB_SAT_EN to clamp overflowed results to MAX_POS/MIN_NEG at push time.
module addsub_result_stage
    import addsub_pkg::*;
#(
    parameter int WIDTH = addsub_pkg::WIDTH,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] res_i,
    input  logic                    over_i,
    input  logic                    carry_i,
    input  logic                    op_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] res_o,
    output logic                    ovf_o,
    output logic                    carry_o,
    output logic                    op_o,
    output logic                    sat_o,
    input  logic                    clear_i,
    output logic                    ovf_sticky,
    output logic [CNT_W-1:0]        ovf_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    addsub_res_t entry_in, head;
    logic        push;

    // An overflowed sum with a clear sign bit really went negative, and vice versa
    function automatic addsub_res_t make_entry(input logic signed [WIDTH-1:0] res,
                                               input logic over,
                                               input logic carry,
                                               input logic op);
        addsub_res_t e;
        e.res   = res;
        e.over  = over;
        e.carry = carry;
        e.op    = op;
        e.sat   = 1'b0;
`ifdef ADDSUB_SAT_EN
        if (over) begin
            e.res = res[WIDTH-1] ? MAX_POS : MIN_NEG;
            e.sat = 1'b1;
        end
`endif
        return e;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    endfunction

    assign entry_in = make_entry(res_i, over_i, carry_i, op_i);
    assign push     = in_valid && in_ready;

    addsub_fifo2 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (entry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (head)
    );

    // Storage is not reset; gating on out_valid gives zero payload after reset
    assign res_o   = out_valid ? head.res   : '0;
    assign ovf_o   = out_valid ? head.over  : 1'b0;
    assign carry_o = out_valid ? head.carry : 1'b0;
    assign op_o    = out_valid ? head.op    : 1'b0;
    assign sat_o   = out_valid ? head.sat   : 1'b0;

    // Clear lands before a same-cycle overflow push, so that beat counts as the first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            ovf_cnt    <= '0;
        end else if (push && over_i) begin
            ovf_sticky <= 1'b1;
            ovf_cnt    <= clear_i ? CNT_W'(1) : cnt_inc_sat(ovf_cnt);
        end else if (clear_i) begin
            ovf_sticky <= 1'b0;
            ovf_cnt    <= '0;
        end
    end

endmodule

// File: tb/tb_addsub_result_stage.sv
// Directed bench for addsub_result_stage; expectations follow ADDSUB_SAT_EN when defined.
module tb_addsub_result_stage;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] res_i;
    logic               over_i;
    logic               carry_i;
    logic               op_i;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] res_o;
    logic               ovf_o;
    logic               carry_o;
    logic               op_o;
    logic               sat_o;
    logic               clear_i;
    logic               ovf_sticky;
    logic [7:0]         ovf_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    addsub_result_stage #(.WIDTH(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .res_i      (res_i),
        .over_i     (over_i),
        .carry_i    (carry_i),
        .op_i       (op_i),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .res_o      (res_o),
        .ovf_o      (ovf_o),
        .carry_o    (carry_o),
        .op_o       (op_o),
        .sat_o      (sat_o),
        .clear_i    (clear_i),
        .ovf_sticky (ovf_sticky),
        .ovf_cnt    (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Drive one beat on the falling edge, then step to just after the rising edge
    task automatic beat(input logic signed [15:0] r, input logic ov, input logic cy, input logic op);
        @(negedge clk);
        in_valid = 1'b1;
        res_i    = r;
        over_i   = ov;
        carry_i  = cy;
        op_i     = op;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        over_i   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        res_i     = '0;
        over_i    = 1'b0;
        carry_i   = 1'b0;
        op_i      = 1'b0;
        out_ready = 1'b1;
        clear_i   = 1'b0;
        #12;
        chk("rst_in_ready",  32'(in_ready),   1);
        chk("rst_out_valid", 32'(out_valid),  0);
        chk("rst_res_o",     32'(res_o),      0);
        chk("rst_sat_o",     32'(sat_o),      0);
        chk("rst_sticky",    32'(ovf_sticky), 0);
        chk("rst_cnt",       32'(ovf_cnt),    0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2000 + 1000
        beat(16'sd3000, 1'b0, 1'b0, 1'b0);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_res",   32'(res_o),     3000);
        chk("add_ovf",   32'(ovf_o),     0);
        chk("add_sat",   32'(sat_o),     0);
        chk("add_op",    32'(op_o),      0);

        // 30000 + 10000 wraps to -25536
        beat(-16'sd25536, 1'b1, 1'b0, 1'b0);
        chk("posovf_res",    32'(res_o),      SAT ? 32767 : -25536);
        chk("posovf_sat",    32'(sat_o),      SAT ? 1 : 0);
        chk("posovf_ovf",    32'(ovf_o),      1);
        chk("posovf_cnt",    32'(ovf_cnt),    1);
        chk("posovf_sticky", 32'(ovf_sticky), 1);

        // -30000 - 10000 wraps to 25536
        beat(16'sd25536, 1'b1, 1'b1, 1'b1);
        chk("negovf_res",   32'(res_o),   SAT ? -32768 : 25536);
        chk("negovf_sat",   32'(sat_o),   SAT ? 1 : 0);
        chk("negovf_op",    32'(op_o),    1);
        chk("negovf_carry", 32'(carry_o), 1);
        chk("negovf_cnt",   32'(ovf_cnt), 2);

        idle();
        chk("drain_valid", 32'(out_valid), 0);

        // Backpressure: three beats offered while out_ready is low
        @(negedge clk);
        out_ready = 1'b0;
        beat(16'sd1, 1'b0, 1'b0, 1'b0);
        chk("bp1_valid", 32'(out_valid), 1);
        chk("bp1_ready", 32'(in_ready),  1);
        beat(16'sd2, 1'b0, 1'b0, 1'b0);
        chk("bp2_ready", 32'(in_ready),  0);
        chk("bp2_res",   32'(res_o),     1);
        beat(16'sd3, 1'b0, 1'b0, 1'b0);
        chk("bp3_ready", 32'(in_ready),  0);
        chk("bp3_res",   32'(res_o),     1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_res2",   32'(res_o),    2);
        chk("rel_ready",  32'(in_ready), 1);
        beat(16'sd3, 1'b0, 1'b0, 1'b0);
        chk("rel_res3",   32'(res_o),     3);
        chk("rel_valid3", 32'(out_valid), 1);
        idle();
        chk("rel_empty",  32'(out_valid), 0);

        // Counter saturation then clear with a same-cycle overflow beat
        for (int i = 0; i < 300; i++) beat(-16'sd100, 1'b1, 1'b0, 1'b0);
        chk("cnt_hold",   32'(ovf_cnt),    255);
        chk("cnt_sticky", 32'(ovf_sticky), 1);
        @(negedge clk);
        clear_i = 1'b1;
        beat(-16'sd100, 1'b1, 1'b0, 1'b0);
        chk("clr_ovf_cnt",    32'(ovf_cnt),    1);
        chk("clr_ovf_sticky", 32'(ovf_sticky), 1);
        idle();
        chk("clr_cnt",    32'(ovf_cnt),    0);
        chk("clr_sticky", 32'(ovf_sticky), 0);
        @(negedge clk);
        clear_i = 1'b0;

        // Asynchronous reset with two entries buffered
        @(negedge clk);
        out_ready = 1'b0;
        beat(16'sd10, 1'b0, 1'b0, 1'b0);
        beat(16'sd20, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_ready", 32'(in_ready), 0);
        chk("pre_rst_cnt",   32'(ovf_cnt),  1);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        over_i   = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_ready", 32'(in_ready),  1);
        chk("arst_cnt",   32'(ovf_cnt),   0);
        chk("arst_res",   32'(res_o),     0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(out_valid), 0);
        beat(16'sd77, 1'b0, 1'b0, 1'b0);
        chk("post_rst_res", 32'(res_o), 77);
        idle();
        chk("post_rst_empty", 32'(out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_result_stage.md
# addsub_result_stage

Registered output stage that sits directly downstream of `adder_sub`. It captures each 16-bit signed result with its `over`/`carry` flags and the `Op` that produced it. Results are held in a 2-entry buffer behind a valid/ready handshake, so the combinational adder never sees backpressure timing. The stage optionally saturates overflowed results and keeps overflow statistics for software.

## Interface
Parameters:
- `WIDTH`, 16, datapath width; must match `adder_sub`.
- `CNT_W`, 8, width of the overflow event counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat; equals "buffer not full", driven from a register.
- `res_i`  in  WIDTH  signed result from `adder_sub` `Out`.
- `over_i`  in  1  signed overflow from `adder_sub`.
- `carry_i`  in  1  carry/borrow from `adder_sub`.
- `op_i`  in  1  operation tag: 0 = add, 1 = subtract.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream accepts the head entry.
- `res_o`  out  WIDTH  signed result, saturated if configured.
- `ovf_o`  out  1  overflow flag of the head entry.
- `carry_o`  out  1  carry of the head entry.
- `op_o`  out  1  op tag of the head entry.
- `sat_o`  out  1  head entry was saturated.
- `clear_i`  in  1  synchronous clear of the statistics.
- `ovf_sticky`  out  1  at least one overflow accepted since the last clear or reset.
- `ovf_cnt`  out  CNT_W  number of overflow beats accepted, saturating.

## Operation
- Push on `in_valid && in_ready`. Pop on `out_valid && out_ready`.
- Buffer is a 2-entry FIFO with 2-bit occupancy count 0..2 and 1-bit read/write pointers that wrap.
- Saturation happens at push time, on the value being written:
  - `over_i=1` and `res_i[WIDTH-1]=0`: the true result is negative, so store `MIN_NEG` (0x8000).
  - `over_i=1` and `res_i[WIDTH-1]=1`: store `MAX_POS` (0x7FFF).
  - `sat_o` is set for that entry.
- When a pushed beat has `over_i=1`:
  - `ovf_sticky` is set.
  - `ovf_cnt` increments and holds at 2^CNT_W−1.
- `clear_i` zeroes `ovf_sticky` and `ovf_cnt`. If an overflow beat is pushed in the same cycle, the clear is applied first and that beat is then counted: `cnt=1`, `sticky=1`.
- Buffer state machine (by occupancy):
  - EMPTY → ONE on push.
  - ONE → TWO on push without pop.
  - ONE → EMPTY on pop without push.
  - ONE stays ONE on simultaneous push and pop.
  - TWO → ONE on pop. No push is possible in TWO.
- `res_o` and the other payload outputs are don't-care while `out_valid=0`. Data must remain stable while `out_valid && !out_ready`.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `res_o=0`, `ovf_o=0`, `carry_o=0`, `op_o=0`, `sat_o=0`, `ovf_sticky=0`, `ovf_cnt=0`, pointers 0.
- Latency is 1 cycle: a beat pushed at edge N is visible with `out_valid=1` after edge N. There is no combinational bypass.
- Throughput is 1 beat/cycle with `out_ready` held high.
- `in_ready` falls the cycle after the buffer reaches TWO and rises the cycle after a pop from TWO. There is no combinational path from `out_ready` to `in_ready`.
- Asserting `rst_n` low mid-operation immediately (asynchronously) discards all entries and forces the reset values above.

## Configuration
- `ADDSUB_SAT_EN` defined: saturation is applied as described in Operation.
- `ADDSUB_SAT_EN` undefined: `res_o` carries `res_i` unchanged (wrapped) and `sat_o` is tied 0.
- Statistics and `ovf_o` behave identically in both builds.

## Structure
- Package `addsub_pkg` contains:
  - `WIDTH`, `MAX_POS`, `MIN_NEG` constants.
  - Typedef `addsub_res_t`, a packed struct {res, over, carry, op, sat} used as the FIFO entry.
- Sub-module `addsub_fifo2`: generic 2-entry FIFO of `addsub_res_t` with the occupancy state machine.
- The top level holds saturation logic and statistics.

## Test plan
- Push 2000+1000 (Op=0) with `out_ready=1`: next cycle `res_o=3000`, `ovf_o=0`, `sat_o=0`, `op_o=0`.
- Push `res_i=-25536`, `over_i=1` (30000+10000):
  - With `ADDSUB_SAT_EN`: `res_o=32767`, `sat_o=1`, `ovf_cnt=1`, `ovf_sticky=1`.
  - Without the macro: `res_o=-25536`, `sat_o=0`.
- Push `res_i=25536`, `over_i=1` (−30000−10000), macro on: `res_o=-32768`, `sat_o=1`.
- Hold `out_ready=0` and offer 3 beats (1, 2, 3):
  - `in_ready=0` after the 2nd push and beat 3 stalls.
  - Release `out_ready`: outputs arrive in order 1, 2, 3 with no loss or duplication.
- Push 300 overflow beats: `ovf_cnt` holds at 255. Then `clear_i` together with one overflow beat gives `ovf_cnt=1`, `ovf_sticky=1`.
- With 2 entries buffered, pulse `rst_n` low: `out_valid=0`, `in_ready=1`, `ovf_cnt=0` immediately, and no stale entry appears after release.
